// File: rtl/uart_rx_core_if.sv
// Receive-FIFO read port of uart_rx_core.
// master: the consumer that pops words; slave: the receiver core.
interface uart_rx_core_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                          rd_en;
  logic [DATA_BITS-1:0]          rd_data;
  logic                          rd_valid;
  logic                          fifo_full;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_valid,
    input  fifo_full,
    input  fifo_level
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_valid,
    output fifo_full,
    output fifo_level
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver with rx synchroniser, frame FSM,
// optional parity, one or two stop bits, show-ahead receive FIFO and sticky
// error flags.
//
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//   defined   - each bit is the 2-of-3 vote of the ticks centre-1/centre/centre+1.
//               The vote resolves on the centre+1 tick, so the counter is
//               re-seeded one step ahead to keep the bit centres unchanged.
//   undefined - single sample at the centre tick.
//
// state  | meaning
// IDLE   | line idle, waiting for a synchronised falling edge
// START  | checking the start bit at its centre
// DATA   | shifting in DATA_BITS bits, LSB first
// PARITY | checking the parity bit (only when parity is enabled)
// STOP1  | checking the first stop bit
// STOP2  | checking the second stop bit (only when two stop bits)
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           rx_i,
  input  logic           baud_tick_i,
  input  logic           parity_en_i,
  input  logic           parity_odd_i,
  input  logic           stop_bits2_i,
  input  logic           err_clear_i,
  output logic           frame_err_o,
  output logic           parity_err_o,
  output logic           overrun_err_o,
  output logic           busy_o,
  uart_rx_core_if.slave  rd_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] BIT_PT   = '0;
  localparam logic [CW-1:0] RESTART  = CW'(1);
`else
  localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] BIT_PT   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] RESTART  = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   bad_frame_q, bad_frame_d;
  logic                   bad_par_q, bad_par_d;
  logic                   cfg_par_en_q, cfg_par_en_d;
  logic                   cfg_par_odd_q, cfg_par_odd_d;
  logic                   cfg_stop2_q, cfg_stop2_d;
  logic                   frame_err_q, parity_err_q, overrun_err_q;
  logic [LW-1:0]          level_q, level_d;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic rx_s, fall, bit_val, sample, last_stop, frame_bad_now;
  logic full, push, pop, set_fe, set_pe, set_oe;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev_q & ~rx_s;

  // Synchroniser and edge history, preset high so reset never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // Samples taken at the two previous baud ticks for the 2-of-3 vote.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '1;
    end else if (baud_tick_i) begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign sample = baud_tick_i && (cnt_q == ((state_q == S_START) ? START_PT : BIT_PT));

  // Frame FSM state and per-frame datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      par_q         <= 1'b0;
      bad_frame_q   <= 1'b0;
      bad_par_q     <= 1'b0;
      cfg_par_en_q  <= 1'b0;
      cfg_par_odd_q <= 1'b0;
      cfg_stop2_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      par_q         <= par_d;
      bad_frame_q   <= bad_frame_d;
      bad_par_q     <= bad_par_d;
      cfg_par_en_q  <= cfg_par_en_d;
      cfg_par_odd_q <= cfg_par_odd_d;
      cfg_stop2_q   <= cfg_stop2_d;
    end
  end

  // Next-state logic; the counter free-runs on baud ticks unless the FSM re-seeds it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    bad_frame_d   = bad_frame_q;
    bad_par_d     = bad_par_q;
    cfg_par_en_d  = cfg_par_en_q;
    cfg_par_odd_d = cfg_par_odd_q;
    cfg_stop2_d   = cfg_stop2_q;
    last_stop     = 1'b0;

    if (baud_tick_i) begin
      cnt_d = (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d       = S_START;
          cnt_d         = '0;
          bit_idx_d     = '0;
          par_d         = 1'b0;
          bad_frame_d   = 1'b0;
          bad_par_d     = 1'b0;
          cfg_par_en_d  = parity_en_i;
          cfg_par_odd_d = parity_odd_i;
          cfg_stop2_d   = stop_bits2_i;
        end
      end
      S_START: begin
        if (sample) begin
          if (bit_val) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = RESTART;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
          par_d   = par_q ^ bit_val;
          if (bit_idx_q == BW'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = cfg_par_en_q ? S_PARITY : S_STOP1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          if (bit_val != (par_q ^ cfg_par_odd_q)) begin
            bad_par_d = 1'b1;
          end
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (sample) begin
          if (!bit_val) begin
            bad_frame_d = 1'b1;
          end
          if (cfg_stop2_q) begin
            state_d = S_STOP2;
          end else begin
            last_stop = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (sample) begin
          if (!bit_val) begin
            bad_frame_d = 1'b1;
          end
          last_stop = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word disposition at the last stop sample: frame error beats parity error beats overrun.
  always_comb begin
    frame_bad_now = bad_frame_q | ~bit_val;
    full          = (level_q == LW'(FIFO_DEPTH));
    pop           = rd_if.rd_en & (level_q != '0);
    set_fe        = last_stop & frame_bad_now;
    set_pe        = last_stop & ~frame_bad_now & bad_par_q;
    set_oe        = last_stop & ~frame_bad_now & ~bad_par_q & full & ~rd_if.rd_en;
    push          = last_stop & ~frame_bad_now & ~bad_par_q & (~full | rd_if.rd_en);
    level_d       = level_q + LW'(push) - LW'(pop);
  end

  // FIFO pointers, level and sticky flags (a set in the clear cycle wins).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      level_q       <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      frame_err_q   <= set_fe | (frame_err_q   & ~err_clear_i);
      parity_err_q  <= set_pe | (parity_err_q  & ~err_clear_i);
      overrun_err_q <= set_oe | (overrun_err_q & ~err_clear_i);
    end
  end

  // FIFO storage; contents are only visible while the level is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  assign rd_if.rd_data    = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign rd_if.rd_valid   = (level_q != '0);
  assign rd_if.fifo_full  = full;
  assign rd_if.fifo_level = level_q;
  assign frame_err_o      = frame_err_q;
  assign parity_err_o     = parity_err_q;
  assign overrun_err_o    = overrun_err_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed plus randomised bench for uart_rx_core (8 data bits, 16x oversample,
// 16-deep FIFO, one baud tick every 4 clocks => 64 clocks per bit).
module tb_uart_rx_core;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam bit MAJ = 1'b1;
  localparam int DEC_OFS = 4;
`else
  localparam bit MAJ = 1'b0;
  localparam int DEC_OFS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic parity_en = 1'b0, parity_odd = 1'b0, stop_bits2 = 1'b0, err_clear = 1'b0;
  logic frame_err, parity_err, overrun_err, busy;
  logic [1:0] div_q = 2'd0;
  logic baud_tick;

  uart_rx_core_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) rd_if ();

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .baud_tick_i(baud_tick),
    .parity_en_i(parity_en), .parity_odd_i(parity_odd), .stop_bits2_i(stop_bits2),
    .err_clear_i(err_clear), .frame_err_o(frame_err), .parity_err_o(parity_err),
    .overrun_err_o(overrun_err), .busy_o(busy), .rd_if(rd_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) div_q <= div_q + 2'd1;
  assign baud_tick = (div_q == 2'd3);

  int total = 0;
  int bad = 0;
  logic [7:0] mq[$];
  bit m_fe = 0, m_pe = 0, m_oe = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    chk({tag, ".level"}, 32'(rd_if.fifo_level), 32'(mq.size()));
    chk({tag, ".valid"}, 32'(rd_if.rd_valid), 32'(mq.size() != 0));
    chk({tag, ".full"}, 32'(rd_if.fifo_full), 32'(mq.size() == 16));
    chk({tag, ".data"}, 32'(rd_if.rd_data), 32'(head));
    chk({tag, ".fe"}, 32'(frame_err), 32'(m_fe));
    chk({tag, ".pe"}, 32'(parity_err), 32'(m_pe));
    chk({tag, ".oe"}, 32'(overrun_err), 32'(m_oe));
    chk({tag, ".busy"}, 32'(busy), 32'(0));
  endtask

  // Wait for the negedge just after a baud tick was consumed.
  task automatic align();
    do @(negedge clk); while (div_q != 2'd0);
  endtask

  // Send one frame with the current configuration, then one idle bit time.
  task automatic send_frame(input logic [7:0] data, input bit par_flip, input bit s1,
                            input bit s2, input bit rd_at_stop, input bit glitch);
    logic bits[$];
    logic [7:0] got;
    int nb, dec;
    bit bad_frame, bad_par, full_before;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (parity_en) bits.push_back((^data) ^ parity_odd ^ par_flip);
    bits.push_back(s1);
    if (stop_bits2) bits.push_back(s2);
    nb  = bits.size();
    dec = 32 + 64 * (nb - 1) - 1 + DEC_OFS;
    align();
    for (int c = 0; c < nb * 64 + 64; c++) begin
      rx = (c < nb * 64) ? bits[c / 64] : 1'b1;
      if (glitch && c >= 93 && c <= 96) rx = 1'b1;
      rd_if.rd_en = rd_at_stop && (c == dec);
      @(negedge clk);
    end
    rd_if.rd_en = 1'b0;
    rx = 1'b1;
    got = data;
    if (glitch && !MAJ) got[0] = 1'b1;
    bad_frame   = !s1 || (stop_bits2 && !s2);
    bad_par     = parity_en && par_flip;
    full_before = (mq.size() == 16);
    if (rd_at_stop && mq.size() != 0) void'(mq.pop_front());
    if (bad_frame) m_fe = 1;
    else if (bad_par) m_pe = 1;
    else if (full_before && !rd_at_stop) m_oe = 1;
    else mq.push_back(got);
  endtask

  task automatic pop_word(input string tag);
    chk({tag, ".rd"}, 32'(rd_if.rd_data), 32'((mq.size() != 0) ? mq[0] : 8'h00));
    rd_if.rd_en = 1'b1;
    @(negedge clk);
    rd_if.rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_fe = 0; m_pe = 0; m_oe = 0;
  endtask

  task automatic set_cfg(input bit pe, input bit po, input bit s2);
    parity_en = pe; parity_odd = po; stop_bits2 = s2;
  endtask

  initial begin
    bit seen_busy;
    rd_if.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5, then pop
    set_cfg(0, 0, 0);
    send_frame(8'hA5, 0, 1, 1, 0, 0);
    chk("t1.a5", 32'(rd_if.rd_data), 32'h0A5);
    check_all("t1");
    pop_word("t1");
    check_all("t1.pop");

    // short low pulse: start rejected
    seen_busy = 0;
    align();
    for (int c = 0; c < 128; c++) begin
      rx = (c < 16) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    chk("t2.busy_pulse", 32'(seen_busy), 32'(1));
    check_all("t2");

    // odd parity on 0x3C: wrong parity bit then correct
    set_cfg(1, 1, 0);
    send_frame(8'h3C, 1, 1, 1, 0, 0);
    chk("t3.pe", 32'(parity_err), 32'(1));
    check_all("t3.bad");
    send_frame(8'h3C, 0, 1, 1, 0, 0);
    check_all("t3.good");
    pop_word("t3");
    clear_errs();

    // 8N2 with bad second stop bit, then clear
    set_cfg(0, 0, 1);
    send_frame(8'h5A, 0, 1, 0, 0, 0);
    chk("t4.fe", 32'(frame_err), 32'(1));
    check_all("t4.bad");
    clear_errs();
    check_all("t4.clr");

    // break: rx held low for several frame times
    set_cfg(0, 0, 0);
    align();
    rx = 1'b0;
    repeat (3 * 704) @(negedge clk);
    m_fe = 1;
    check_all("brk.low");
    rx = 1'b1;
    repeat (128) @(negedge clk);
    check_all("brk.high");
    clear_errs();

    // fill to full, overrun, drain
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 0, 1, 1, 0, 0);
      check_all("t5.fill");
    end
    chk("t5.oe", 32'(overrun_err), 32'(1));
    for (int i = 0; i < 16; i++) pop_word("t5.drain");
    check_all("t5.empty");
    clear_errs();
    for (int i = 0; i < 16; i++) send_frame(8'($urandom_range(0, 255)), 0, 1, 1, 0, 0);
    send_frame(8'h10, 0, 1, 1, 1, 0);
    check_all("t5.rd_at_stop");
    for (int i = 0; i < 16; i++) pop_word("t5.drain2");
    check_all("t5.empty2");

    // randomised frames against the model
    for (int n = 0; n < 10; n++) begin
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 3) == 0), 0);
      check_all("rnd");
      if ($urandom_range(0, 2) == 0) pop_word("rnd");
      if ($urandom_range(0, 3) == 0) clear_errs();
    end

    // glitch in data bit 0, then async reset mid-frame
    while (mq.size() != 0) pop_word("t6.drain");
    set_cfg(0, 0, 0);
    send_frame(8'h00, 0, 1, 1, 0, 1);
    chk("t6.glitch", 32'(rd_if.rd_data), MAJ ? 32'h00 : 32'h01);
    check_all("t6");
    align();
    rx = 1'b0;
    repeat (200) @(negedge clk);
    chk("t6.busy_before", 32'(busy), 32'(1));
    #3 rst_n = 1'b0;
    rx = 1'b1;
    #1;
    mq.delete(); m_fe = 0; m_pe = 0; m_oe = 0;
    check_all("t6.in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_all("t6.after_reset");
    send_frame(8'hC3, 0, 1, 1, 0, 0);
    check_all("t6.resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
